// File: rtl/sram_ctrl.sv
// sram_ctrl: turns single-cycle read/write requests into SETUP / ACCESS / HOLD
// strobe sequences for an asynchronous 8-bit SRAM.
// - All SRAM-side outputs are registered and decoded from the next state.
// - The shared data bus is driven only while a write is in flight.
module sram_ctrl #(
   parameter int size = 5,
   parameter int WAIT = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req,
   input  logic            we,
   input  logic [size-1:0] addr_in,
   input  logic [7:0]      wdata,
   output logic            ready,
   output logic            done,
   output logic [7:0]      rdata,
   output logic            CE,
   output logic            WR,
   output logic            OE,
   output logic [size-1:0] addr,
   inout  wire  [7:0]      data
);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

   // ACCESS lasts WAIT cycles: the counter runs WAIT-1 .. 0
   localparam logic [3:0] CNT_LOAD = 4'(WAIT - 1);

   state_t          state_reg, state_next;
   logic [3:0]      cnt_reg, cnt_next;
   logic            we_reg;
   logic [size-1:0] addr_reg;
   logic [7:0]      wdata_reg;
   logic [7:0]      rdata_reg;
   logic            ce_reg, wr_reg, oe_reg, drive_reg, done_reg;
   logic            ce_next, wr_next, oe_next, drive_next, done_next;
   logic            txn_we;
   logic            accept;
   logic            capture;

   assign accept  = (state_reg == IDLE) && req;
   // Read data is sampled on the edge that ends the last ACCESS cycle
   assign capture = (state_reg == ACCESS) && (cnt_reg == 4'd0) && !we_reg;
   // On the accepting edge the direction still comes straight from the request
   assign txn_we  = (state_reg == IDLE) ? we : we_reg;

   // Next-state logic, counter, and next values of the registered strobes
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         IDLE: begin
            if (req) state_next = SETUP;
         end
         SETUP: begin
            state_next = ACCESS;
            cnt_next   = CNT_LOAD;
         end
         ACCESS: begin
            if (cnt_reg == 4'd0) state_next = HOLD;
            else                 cnt_next   = cnt_reg - 4'd1;
         end
         HOLD: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
      ce_next    = (state_next != IDLE);
      wr_next    = (state_next == ACCESS) && txn_we;
      oe_next    = (state_next == ACCESS) && !txn_we;
      drive_next = (state_next != IDLE) && txn_we;
      done_next  = (state_next == HOLD);
   end

   // State, counter and strobe registers; reset drops the bus driver at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         cnt_reg   <= 4'd0;
         ce_reg    <= 1'b0;
         wr_reg    <= 1'b0;
         oe_reg    <= 1'b0;
         drive_reg <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         ce_reg    <= ce_next;
         wr_reg    <= wr_next;
         oe_reg    <= oe_next;
         drive_reg <= drive_next;
         done_reg  <= done_next;
      end
   end

   // Transaction latch on acceptance, and the read-data capture register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_reg    <= 1'b0;
         addr_reg  <= '0;
         wdata_reg <= 8'h00;
         rdata_reg <= 8'h00;
      end else begin
         if (accept) begin
            we_reg    <= we;
            addr_reg  <= addr_in;
            wdata_reg <= wdata;
         end
         if (capture) rdata_reg <= data;
      end
   end

   assign ready = (state_reg == IDLE);
   assign done  = done_reg;
   assign rdata = rdata_reg;
   assign CE    = ce_reg;
   assign WR    = wr_reg;
   assign OE    = oe_reg;
   assign addr  = addr_reg;
   assign data  = drive_reg ? wdata_reg : 8'bz;

endmodule
